framed_shift_register: RTL and testbench
========================================

# framed_shift_register

Parametrised shift register for the SPI datapath: parallel load, serial shift on a synchronised peripheral clock edge strobe, and a selectable MSB-first/LSB-first bit order. A built-in bit counter tracks a WIDTH-bit frame and pulses `frameDone` when the frame completes. It replaces the fixed-width, fixed-direction shift register in the SPI memory path, so the FSM no longer needs to count bits.

## Interface
- `WIDTH`, 8, register width in bits; must be at least 2.
- `CNT_W`, $clog2(WIDTH+1), width of the bit counter; derived, never overridden.

- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `peripheralClkEdge` in 1: one-cycle shift strobe from the input conditioner.
- `parallelLoad` in 1: load strobe; starts a frame.
- `parallelDataIn` in WIDTH: load value.
- `serialDataIn` in 1: bit shifted in.
- `lsbFirst` in 1: bit order; sampled only on load.
- `parallelDataOut` out WIDTH: register contents.
- `serialDataOut` out 1: outgoing bit.
- `bitCount` out CNT_W: shifts taken in the current frame.
- `busy` out 1: a frame is in progress.
- `frameDone` out 1: one-cycle pulse when the frame completes.

## Operation
- States: IDLE (`busy`=0) and SHIFTING (`busy`=1).
- Reset, asynchronous, takes effect immediately:
  - register = 0, `bitCount` = 0, `busy` = 0, `frameDone` = 0.
  - Latched direction = MSB-first, so `serialDataOut` = 0.
- Load (`parallelLoad`=1, any state):
  - register <= `parallelDataIn`, `bitCount` <= 0.
  - Latched direction <= `lsbFirst`; state -> SHIFTING.
- Shift (`peripheralClkEdge`=1 and `parallelLoad`=0):
  - MSB-first: register <= {register[WIDTH-2:0], `serialDataIn`}.
  - LSB-first: register <= {`serialDataIn`, register[WIDTH-1:1]}.
- Counting:
  - In SHIFTING, every shift increments `bitCount`.
  - The shift that takes `bitCount` from WIDTH-1 to WIDTH sets `frameDone` for one cycle and returns the block to IDLE.
- Shifts in IDLE still move data; `bitCount` holds (saturates at WIDTH) and `frameDone` stays 0.
- `serialDataOut` is combinational from the register: register[WIDTH-1] when MSB-first, register[0] when LSB-first.
- Priority: reset > load > shift > hold. Simultaneous load and shift performs the load only.
- A change of `lsbFirst` mid-frame is ignored until the next load.
- A load mid-frame aborts the current frame without a `frameDone` pulse and starts a new one.
- Neither strobe asserted: all state holds; `frameDone` returns to 0.

## Timing
- Load and shift take effect on the rising edge that samples the strobe.
- `parallelDataOut`, `bitCount` and `busy` are valid one cycle after the strobe; `serialDataOut` follows the register with no extra delay.
- `frameDone` is registered:
  - high during the cycle after the WIDTH-th shift edge, coincident with the final `parallelDataOut`;
  - never high for two consecutive cycles, even with back-to-back strobes.
- A full frame takes WIDTH strobes; strobes may arrive on consecutive cycles.
- Releasing reset mid-frame leaves the block in IDLE with zeroed state; a new load is required to start a frame.

## Structure
- Shared package `spi_pkg`:
  - bit-order constants `MSB_FIRST`=0 and `LSB_FIRST`=1;
  - a count-width helper function, reused by the SPI FSM.
- Sub-module `bit_counter`: saturating, loadable WIDTH+1-state counter with a terminal-count pulse. Everything else stays in one module.

## Test plan
All scenarios use WIDTH=8.
1. Reset mid-frame: load 0xA5, 3 shifts, pulse `reset` between edges -> immediately `parallelDataOut`=0x00, `serialDataOut`=0, `bitCount`=0, `busy`=0, `frameDone`=0.
2. MSB-first: load 0x01 with `lsbFirst`=0, shift in 1 then 0 -> `parallelDataOut`=0x06, `serialDataOut`=0, `bitCount`=2, `busy`=1.
3. LSB-first: load 0x81 with `lsbFirst`=1 -> `serialDataOut`=1; shift in 0 -> `parallelDataOut`=0x40, `serialDataOut`=0.
4. Full frame: load 0xC3 MSB-first, then 8 back-to-back shifts of serial pattern 0x5A, MSB first:
   - `serialDataOut` before each shift = 1,1,0,0,0,0,1,1;
   - afterwards `parallelDataOut`=0x5A, `bitCount`=8, `busy`=0, `frameDone` high exactly one cycle.
   - A 9th shift -> `bitCount` stays 8, no `frameDone`.
5. Simultaneous strobes: register 0x80, assert `parallelLoad` and `peripheralClkEdge` together with `parallelDataIn`=0x3C, `serialDataIn`=1 -> `parallelDataOut`=0x3C, `bitCount`=0, no shift.
6. Mid-frame changes:
   - Load 0x0F MSB-first, toggle `lsbFirst` to 1 after 2 shifts -> later shifts remain MSB-first.
   - Reload mid-frame -> `bitCount`=0 and no `frameDone` pulse.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI datapath types, bit-order constants and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } shiftState_t;

    // Width needed to hold 0..width inclusive; shared with the SPI FSM.
    function automatic int countWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bit_counter
//  Description : Saturating, clearable 0..MAX_COUNT counter with a registered
//                terminal-count pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_counter
    import spi_pkg::*;
#(
    parameter int MAX_COUNT = 8,
    parameter int CNT_W     = countWidth(MAX_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             lastStep,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] c_maxCount  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] c_lastCount = CNT_W'(MAX_COUNT - 1);

    logic w_advance;

    always_comb begin
        w_advance = enable && tick && (count != c_maxCount);
        lastStep  = w_advance && (count == c_lastCount);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            terminal <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            terminal <= 1'b0;
        end else begin
            if (w_advance) begin
                count <= count + CNT_W'(1);
            end
            terminal <= lastStep;
        end
    end

endmodule
`default_nettype wire

// File: rtl/framed_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : framed_shift_register
//  Description : Loadable MSB/LSB-first shift register with WIDTH-bit framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module framed_shift_register
    import spi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = countWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    input  logic             lsbFirst,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut,
    output logic [CNT_W-1:0] bitCount,
    output logic             busy,
    output logic             frameDone
);

    shiftState_t      r_state;
    shiftState_t      w_nextState;
    logic [WIDTH-1:0] r_shiftReg;
    logic             r_lsbFirst;
    logic             w_shiftEn;
    logic             w_lastStep;

    assign w_shiftEn = peripheralClkEdge && !parallelLoad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shiftReg <= '0;
            r_lsbFirst <= MSB_FIRST;
        end else if (parallelLoad) begin
            r_shiftReg <= parallelDataIn;
            r_lsbFirst <= lsbFirst;
        end else if (w_shiftEn) begin
            if (r_lsbFirst == LSB_FIRST) begin
                r_shiftReg <= {serialDataIn, r_shiftReg[WIDTH-1:1]};
            end else begin
                r_shiftReg <= {r_shiftReg[WIDTH-2:0], serialDataIn};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        if (parallelLoad) begin
            w_nextState = SHIFTING;
        end else if (w_lastStep) begin
            w_nextState = IDLE;
        end
        if (r_state == SHIFTING) begin
            busy = 1'b1;
        end
    end

    // Counting only runs inside a frame, so idle shifts leave bitCount parked.
    bit_counter #(
        .MAX_COUNT (WIDTH),
        .CNT_W     (CNT_W)
    ) u_bitCounter (
        .clk      (clk),
        .reset    (reset),
        .clear    (parallelLoad),
        .enable   (r_state == SHIFTING),
        .tick     (w_shiftEn),
        .count    (bitCount),
        .lastStep (w_lastStep),
        .terminal (frameDone)
    );

    assign parallelDataOut = r_shiftReg;
    assign serialDataOut   = (r_lsbFirst == LSB_FIRST) ? r_shiftReg[0] : r_shiftReg[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_framed_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_framed_shift_register
//  Description : Self-checking bench for framed_shift_register (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_framed_shift_register;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         peripheralClkEdge;
    logic         parallelLoad;
    logic [W-1:0] parallelDataIn;
    logic         serialDataIn;
    logic         lsbFirst;
    logic [W-1:0] parallelDataOut;
    logic         serialDataOut;
    logic [3:0]   bitCount;
    logic         busy;
    logic         frameDone;

    int nAsserts = 0;
    int nFail    = 0;

    // Reference model state (plain integers).
    int mReg, mCnt, mBusy, mDone, mLsb;

    always #5 clk = ~clk;

    framed_shift_register #(.WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .peripheralClkEdge (peripheralClkEdge),
        .parallelLoad      (parallelLoad),
        .parallelDataIn    (parallelDataIn),
        .serialDataIn      (serialDataIn),
        .lsbFirst          (lsbFirst),
        .parallelDataOut   (parallelDataOut),
        .serialDataOut     (serialDataOut),
        .bitCount          (bitCount),
        .busy              (busy),
        .frameDone         (frameDone)
    );

    typedef struct {
        bit       load;
        bit       shift;
        bit [7:0] pin;
        bit       sin;
        bit       lsb;
        bit [7:0] expOut;
        bit       expSer;
        int       expCnt;
        bit       expBusy;
        bit       expDone;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        nAsserts++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mReg = 0; mCnt = 0; mBusy = 0; mDone = 0; mLsb = 0;
    endtask

    task automatic modelStep(input bit load, input bit shift, input int pin,
                             input bit sin, input bit lsb);
        int newDone;
        newDone = 0;
        if (load) begin
            mReg = pin; mCnt = 0; mLsb = int'(lsb); mBusy = 1;
        end else if (shift) begin
            if (mLsb != 0) mReg = mReg / 2 + int'(sin) * (2 ** (W - 1));
            else           mReg = (mReg * 2) % (2 ** W) + int'(sin);
            if (mBusy != 0) begin
                mCnt = mCnt + 1;
                if (mCnt == W) begin
                    mBusy = 0;
                    newDone = 1;
                end
            end
        end
        mDone = newDone;
    endtask

    function automatic int modelSer();
        return (mLsb != 0) ? (mReg % 2) : ((mReg / (2 ** (W - 1))) % 2);
    endfunction

    task automatic checkModel(input string tag);
        chk({tag, ".out"},  int'(parallelDataOut), mReg);
        chk({tag, ".ser"},  int'(serialDataOut),   modelSer());
        chk({tag, ".cnt"},  int'(bitCount),        mCnt);
        chk({tag, ".busy"}, int'(busy),            mBusy);
        chk({tag, ".done"}, int'(frameDone),       mDone);
    endtask

    // Apply one cycle of strobes, advance the model, sample 1 time unit after the edge.
    task automatic drive(input bit load, input bit shift, input int pin,
                         input bit sin, input bit lsb);
        parallelLoad      = load;
        peripheralClkEdge = shift;
        parallelDataIn    = W'(pin);
        serialDataIn      = sin;
        lsbFirst          = lsb;
        @(posedge clk);
        #1;
        modelStep(load, shift, pin, sin, lsb);
    endtask

    task automatic resetPulse(input string tag);
        #2 reset = 1'b1;
        #1;
        modelReset();
        chk({tag, ".out"},  int'(parallelDataOut), 0);
        chk({tag, ".ser"},  int'(serialDataOut),   0);
        chk({tag, ".cnt"},  int'(bitCount),        0);
        chk({tag, ".busy"}, int'(busy),            0);
        chk({tag, ".done"}, int'(frameDone),       0);
        #1 reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[9];
        bit [7:0] pat;
        int doneSeen;

        vecs[0] = '{1, 0, 8'h01, 0, 0, 8'h01, 0, 0, 1, 0};
        vecs[1] = '{0, 1, 8'h00, 1, 0, 8'h03, 0, 1, 1, 0};
        vecs[2] = '{0, 1, 8'h00, 0, 0, 8'h06, 0, 2, 1, 0};
        vecs[3] = '{1, 0, 8'h81, 0, 1, 8'h81, 1, 0, 1, 0};
        vecs[4] = '{0, 1, 8'h00, 0, 1, 8'h40, 0, 1, 1, 0};
        vecs[5] = '{1, 0, 8'h80, 0, 0, 8'h80, 1, 0, 1, 0};
        vecs[6] = '{1, 1, 8'h3C, 1, 0, 8'h3C, 0, 0, 1, 0};
        vecs[7] = '{0, 0, 8'h00, 0, 0, 8'h3C, 0, 0, 1, 0};
        vecs[8] = '{0, 1, 8'h00, 1, 1, 8'h79, 0, 1, 1, 0};

        reset = 1'b1;
        parallelLoad = 0; peripheralClkEdge = 0; parallelDataIn = '0;
        serialDataIn = 0; lsbFirst = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkModel("reset");
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors: MSB/LSB order, simultaneous strobes, lsbFirst ignored mid-frame.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].load, vecs[i].shift, int'(vecs[i].pin), vecs[i].sin, vecs[i].lsb);
            chk($sformatf("vec%0d.out", i),  int'(parallelDataOut), int'(vecs[i].expOut));
            chk($sformatf("vec%0d.ser", i),  int'(serialDataOut),   int'(vecs[i].expSer));
            chk($sformatf("vec%0d.cnt", i),  int'(bitCount),        vecs[i].expCnt);
            chk($sformatf("vec%0d.busy", i), int'(busy),            int'(vecs[i].expBusy));
            chk($sformatf("vec%0d.done", i), int'(frameDone),       int'(vecs[i].expDone));
        end

        // Reset mid-frame, asserted between clock edges.
        drive(1, 0, 8'hA5, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0);
        resetPulse("midReset");
        drive(0, 1, 0, 1, 0);
        checkModel("idleAfterReset");

        // Full frame 0xC3 -> 0x5A, back-to-back strobes.
        drive(1, 0, 8'hC3, 0, 0);
        pat = 8'h5A;
        for (int i = 0; i < W; i++) begin
            chk($sformatf("frame.serBefore%0d", i), int'(serialDataOut),
                int'((8'hC3 >> (W - 1 - i)) & 8'h01));
            drive(0, 1, 0, pat[W-1-i], 0);
            if (i < W - 1) chk($sformatf("frame.doneEarly%0d", i), int'(frameDone), 0);
        end
        chk("frame.out",  int'(parallelDataOut), 8'h5A);
        chk("frame.cnt",  int'(bitCount),        W);
        chk("frame.busy", int'(busy),            0);
        chk("frame.done", int'(frameDone),       1);
        drive(0, 0, 0, 0, 0);
        chk("frame.doneDrop", int'(frameDone), 0);
        drive(0, 1, 0, 1, 0);
        chk("ninth.cnt",  int'(bitCount),  W);
        chk("ninth.done", int'(frameDone), 0);
        chk("ninth.out",  int'(parallelDataOut), 8'hB5);

        // Reload at count 7 aborts the frame with no done pulse.
        drive(1, 0, 8'h0F, 0, 0);
        doneSeen = 0;
        for (int i = 0; i < W - 1; i++) begin
            drive(0, 1, 0, 0, (i >= 2));
            doneSeen += int'(frameDone);
        end
        chk("midChange.out", int'(parallelDataOut), 8'h80);
        drive(1, 1, 8'h55, 0, 0);
        doneSeen += int'(frameDone);
        chk("reload.cnt",  int'(bitCount), 0);
        chk("reload.busy", int'(busy),     1);
        drive(0, 1, 0, 0, 0);
        doneSeen += int'(frameDone);
        chk("reload.noDone", doneSeen, 0);

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
            checkModel("rand");
            if ($urandom_range(0, 299) == 0) resetPulse("randReset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
`default_nettype wire
